// File: rtl/stopwatch_core.sv
// BCD MM:SS stopwatch core with run, hold and adjust modes driven by edge-detected divider levels.
// Optional clear button when STOPWATCH_CLR_EN is defined.
module stopwatch_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       countclk,
    input  logic       adjclk,
    input  logic       blinkclk,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
`ifdef STOPWATCH_CLR_EN
    input  logic       clr,
`endif
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       blank_min,
    output logic       blank_sec,
    output logic       paused
);

    typedef enum logic [1:0] {MODE_RUN, MODE_HOLD, MODE_ADJUST} mode_t;

    mode_t      mode;
    logic       count_q, adjclk_q, pause_q, blink_q;
    logic       count_tick, adj_tick, pause_tick;
    logic [7:0] min_q, sec_q, min_n, sec_n;
    logic [7:0] min_inc, sec_inc;
    logic       sec_wrap;

`ifdef STOPWATCH_CLR_EN
    logic clr_q;
    logic clr_tick;
    assign clr_tick = clr & ~clr_q;
`endif

    assign count_tick = countclk & ~count_q;
    assign adj_tick   = adjclk & ~adjclk_q;
    assign pause_tick = pause & ~pause_q;

    // Two-digit BCD increment over 00..59; 59 wraps to 00.
    function automatic logic [7:0] inc_field(input logic [7:0] f);
        if (f[3:0] != 4'd9)
            return {f[7:4], f[3:0] + 4'd1};
        else if (f[7:4] != 4'd5)
            return {f[7:4] + 4'd1, 4'd0};
        else
            return 8'h00;
    endfunction

    assign min_inc  = inc_field(min_q);
    assign sec_inc  = inc_field(sec_q);
    assign sec_wrap = (sec_q == 8'h59);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        mode      = adj ? MODE_ADJUST : (paused ? MODE_HOLD : MODE_RUN);
        min_n     = min_q;
        sec_n     = sec_q;
        blank_min = 1'b0;
        blank_sec = 1'b0;

        case (mode)
            MODE_ADJUST: begin
                if (adj_tick) begin
                    if (sel) sec_n = sec_inc;
                    else     min_n = min_inc;
                end
                blank_min = ~sel & blink_q;
                blank_sec =  sel & blink_q;
            end
            MODE_RUN: begin
                if (count_tick) begin
                    sec_n = sec_inc;
                    if (sec_wrap) min_n = min_inc;
                end
            end
            default: ;
        endcase

`ifdef STOPWATCH_CLR_EN
        if (clr_tick) begin
            min_n = 8'h00;
            sec_n = 8'h00;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Previous samples load the live inputs so a level already high does not tick.
            count_q  <= countclk;
            adjclk_q <= adjclk;
            pause_q  <= pause;
            blink_q  <= 1'b0;
            min_q    <= 8'h00;
            sec_q    <= 8'h00;
            paused   <= 1'b0;
        end else begin
            count_q  <= countclk;
            adjclk_q <= adjclk;
            pause_q  <= pause;
            blink_q  <= blinkclk;
            min_q    <= min_n;
            sec_q    <= sec_n;
            if (pause_tick) paused <= ~paused;
        end
    end

`ifdef STOPWATCH_CLR_EN
    always_ff @(posedge clk) begin
        clr_q <= clr;
    end
`endif

    assign min_tens = min_q[7:4];
    assign min_ones = min_q[3:0];
    assign sec_tens = sec_q[7:4];
    assign sec_ones = sec_q[3:0];

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: integer-time reference model feeding a scoreboard,
// a table of adjust-mode vectors, and hand-written sequences for the corner cases.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       rst, countclk, adjclk, blinkclk, pause, adj, sel;
`ifdef STOPWATCH_CLR_EN
    logic       clr;
`endif
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       blank_min, blank_sec, paused;

    stopwatch_core dut (
        .clk(clk), .rst(rst), .countclk(countclk), .adjclk(adjclk), .blinkclk(blinkclk),
        .pause(pause), .adj(adj), .sel(sel),
`ifdef STOPWATCH_CLR_EN
        .clr(clr),
`endif
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .blank_min(blank_min), .blank_sec(blank_sec), .paused(paused)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: time kept as plain integers, digits derived only for comparison.
    int m_min, m_sec;
    bit m_paused, m_blink, p_cnt, p_adj, p_pse, p_clr;
    logic [18:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic logic [15:0] bcd(input int mm, input int ss);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_step();
        bit ct, at, pt, clt;
        clt = 1'b0;
        if (rst) begin
            m_min = 0; m_sec = 0; m_paused = 0; m_blink = 0;
        end else begin
            ct = countclk & ~p_cnt;
            at = adjclk & ~p_adj;
            pt = pause & ~p_pse;
`ifdef STOPWATCH_CLR_EN
            clt = clr & ~p_clr;
`endif
            if (adj) begin
                if (at) begin
                    if (sel) m_sec = (m_sec + 1) % 60;
                    else     m_min = (m_min + 1) % 60;
                end
            end else if (!m_paused && ct) begin
                int t;
                t = (m_min * 60 + m_sec + 1) % 3600;
                m_min = t / 60;
                m_sec = t % 60;
            end
            if (clt) begin m_min = 0; m_sec = 0; end
            if (pt) m_paused = ~m_paused;
            m_blink = blinkclk;
        end
        p_cnt = countclk; p_adj = adjclk; p_pse = pause;
`ifdef STOPWATCH_CLR_EN
        p_clr = clr;
`endif
    endtask

    // One clock: update model, push expectation, clock DUT, pop and compare.
    task automatic tick();
        logic [18:0] exp, act;
        model_step();
        sb_q.push_back({bcd(m_min, m_sec), adj & ~sel & m_blink, adj & sel & m_blink, m_paused});
        @(posedge clk);
        #1;
        act = {digits(), blank_min, blank_sec, paused};
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            exp = sb_q.pop_front();
            check($sformatf("cycle@%0t", $time), {13'd0, act}, {13'd0, exp});
        end
    endtask

    task automatic count_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            countclk = 1'b0; tick();
            countclk = 1'b1; tick();
        end
    endtask

    task automatic adj_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            adjclk = 1'b0; tick();
            adjclk = 1'b1; tick();
        end
    endtask

    task automatic pause_pulse();
        pause = 1'b0; tick();
        pause = 1'b1; tick();
        pause = 1'b0; tick();
    endtask

    typedef struct {
        bit          cnt;
        bit          adjc;
        bit          blink;
        logic [15:0] exp_digits;
        bit          exp_bmin;
        bit          exp_bsec;
    } vec_t;

    vec_t vtab[7];

    initial begin
        // Adjust seconds from 58 with blink; count ticks in v3/v5 must be ignored.
        vtab[0] = '{1'b1, 1'b0, 1'b1, 16'h0058, 1'b0, 1'b1};
        vtab[1] = '{1'b1, 1'b1, 1'b0, 16'h0059, 1'b0, 1'b0};
        vtab[2] = '{1'b0, 1'b0, 1'b1, 16'h0059, 1'b0, 1'b1};
        vtab[3] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1};
        vtab[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vtab[5] = '{1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vtab[6] = '{1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b1};

        rst = 1'b1; countclk = 1'b1; adjclk = 1'b0; blinkclk = 1'b0;
        pause = 1'b0; adj = 1'b0; sel = 1'b0;
`ifdef STOPWATCH_CLR_EN
        clr = 1'b0;
`endif
        p_clr = 1'b0;

        // Reset release with countclk already high.
        tick();
        rst = 1'b0;
        tick();
        check("reset_digits", {16'd0, digits()}, 32'h0000);
        check("reset_paused", {31'd0, paused}, 32'd0);
        check("reset_blanks", {30'd0, blank_min, blank_sec}, 32'd0);

        // 60 count ticks carry into minutes.
        count_pulse(60);
        check("run_60_ticks", {16'd0, digits()}, 32'h0100);

        // Set 59:59 through adjust, then one count tick wraps to 00:00.
        adj = 1'b1; sel = 1'b0; adj_pulse(58);
        sel = 1'b1; adj_pulse(59);
        check("preset_5959", {16'd0, digits()}, 32'h5959);
        adj = 1'b0;
        count_pulse(1);
        check("wrap_0000", {16'd0, digits()}, 32'h0000);

        // Pause edge coincides with a count tick at 00:05.
        count_pulse(5);
        countclk = 1'b0; pause = 1'b0; tick();
        countclk = 1'b1; pause = 1'b1; tick();
        check("pause_same_cycle_digits", {16'd0, digits()}, 32'h0006);
        check("pause_same_cycle_flag", {31'd0, paused}, 32'd1);
        count_pulse(3);
        check("hold_ignores_ticks", {16'd0, digits()}, 32'h0006);
        pause_pulse();
        check("unpause", {31'd0, paused}, 32'd0);

        // Seconds to 58 in adjust, then table-driven adjust/blink vectors.
        adj = 1'b1; sel = 1'b1;
        adj_pulse(52);
        for (int i = 0; i < 7; i++) begin
            countclk = vtab[i].cnt; adjclk = vtab[i].adjc; blinkclk = vtab[i].blink;
            tick();
            check($sformatf("adj_vec%0d_digits", i), {16'd0, digits()}, {16'd0, vtab[i].exp_digits});
            check($sformatf("adj_vec%0d_blanks", i), {30'd0, blank_min, blank_sec},
                  {30'd0, vtab[i].exp_bmin, vtab[i].exp_bsec});
        end
        blinkclk = 1'b0;

        // Minutes adjust at 59:30 with interleaved count ticks, then resume.
        adj_pulse(29);
        sel = 1'b0; adj_pulse(59);
        check("preset_5930", {16'd0, digits()}, 32'h5930);
        count_pulse(1); adj_pulse(1); count_pulse(1);
        check("adj_min_wrap", {16'd0, digits()}, 32'h0030);
        adj = 1'b0;
        count_pulse(1);
        check("resume_run", {16'd0, digits()}, 32'h0031);

`ifdef STOPWATCH_CLR_EN
        // Clear at 12:34 in HOLD on the same cycle as a count tick.
        adj = 1'b1; sel = 1'b0; adj_pulse(12);
        sel = 1'b1; adj_pulse(3);
        adj = 1'b0;
        pause_pulse();
        check("preset_1234", {16'd0, digits()}, 32'h1234);
        countclk = 1'b0; clr = 1'b0; tick();
        countclk = 1'b1; clr = 1'b1; tick();
        check("clr_digits", {16'd0, digits()}, 32'h0000);
        check("clr_paused", {31'd0, paused}, 32'd1);
        clr = 1'b0; tick();
        pause_pulse();
`endif

        // Reset mid-adjust with blink high.
        adj = 1'b1; sel = 1'b1; blinkclk = 1'b1;
        adj_pulse(4);
        pause = 1'b1; tick();
        check("pre_reset_blank", {31'd0, blank_sec}, 32'd1);
        rst = 1'b1; countclk = 1'b0; tick();
        check("midrun_reset_digits", {16'd0, digits()}, 32'h0000);
        check("midrun_reset_flags", {29'd0, blank_min, blank_sec, paused}, 32'd0);
        rst = 1'b0; adj = 1'b0; blinkclk = 1'b0;
        count_pulse(2);
        check("post_reset_run", {16'd0, digits()}, 32'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
